// File: rtl/hack_data_mem_resp.sv
// hack_data_mem_resp: CPU data-memory responder.
// Decodes the CPU data port into data RAM, screen RAM and the keyboard
// register, and forwards every screen write to the display engine through
// a small first-word-fall-through FIFO with a valid/ready handshake.
module hack_data_mem_resp #(
  parameter int RAM_AW  = 14,
  parameter int FIFO_AW = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       addressM,
  input  logic [15:0]       outM,
  input  logic              writeM,
  output logic [15:0]       inM,
  input  logic              kbd_valid,
  input  logic [15:0]       kbd_code,
  output logic              scr_valid,
  output logic [12:0]       scr_addr,
  output logic [15:0]       scr_data,
  input  logic              scr_ready,
  output logic [FIFO_AW:0]  scr_level,
  output logic              scr_ovf
);

  localparam int              RAM_WORDS = 2 ** RAM_AW;
  localparam int              DEPTH     = 2 ** FIFO_AW;
  localparam logic [15:0]     RAM_LIMIT = 16'(RAM_WORDS);
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

  // Storage: RAMs carry no reset, their contents are undefined until written
  logic [15:0] r_ram  [0:RAM_WORDS-1];
  logic [15:0] r_scr  [0:8191];
  logic [28:0] r_fifo [0:DEPTH-1];

  logic [15:0]        r_kbd;
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_level;
  logic               r_ovf;

  logic [14:0] w_a;
  logic        w_in_ram;
  logic        w_in_scr;
  logic        w_in_kbd;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_accept;
  logic        w_unused_bit15;

  // Bit 15 of the CPU address does not take part in decoding
  assign w_a            = addressM[14:0];
  assign w_unused_bit15 = addressM[15];

  assign w_in_ram = ({1'b0, w_a} < RAM_LIMIT);
  assign w_in_scr = (w_a[14:13] == 2'b10);
  assign w_in_kbd = (w_a == 15'h6000);

  assign w_push   = writeM & w_in_scr;
  assign w_pop    = scr_valid & scr_ready;
  assign w_full   = (r_level == FULL_LVL);
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign w_accept = w_push & (~w_full | w_pop);

  // Combinational read mux; unmapped addresses and RAM holes read zero
  always_comb begin
    inM = 16'h0000;
    if (w_in_ram)
      inM = r_ram[w_a[RAM_AW-1:0]];
    else if (w_in_scr)
      inM = r_scr[w_a[12:0]];
    else if (w_in_kbd)
      inM = r_kbd;
  end

  // Data RAM write port
  always_ff @(posedge clk) begin
    if (writeM && w_in_ram)
      r_ram[w_a[RAM_AW-1:0]] <= outM;
  end

  // Screen RAM write port; updated even when the FIFO drops the mirror entry
  always_ff @(posedge clk) begin
    if (w_push)
      r_scr[w_a[12:0]] <= outM;
  end

  // FIFO entry storage
  always_ff @(posedge clk) begin
    if (w_accept)
      r_fifo[r_wptr] <= {w_a[12:0], outM};
  end

  // Keyboard register: last strobed code wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_kbd <= 16'h0000;
    else if (kbd_valid)
      r_kbd <= kbd_code;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_accept && !w_pop)
        r_level <= r_level + 1'b1;
      else if (!w_accept && w_pop)
        r_level <= r_level - 1'b1;
      if (w_push && !w_accept)
        r_ovf <= 1'b1;
    end
  end

  assign scr_valid = (r_level != '0);
  assign scr_addr  = r_fifo[r_rptr][28:16];
  assign scr_data  = r_fifo[r_rptr][15:0];
  assign scr_level = r_level;
  assign scr_ovf   = r_ovf;

endmodule
